// File: rtl/cache_refill_ctrl.sv
// Block refill engine behind the direct-mapped cache, one word per request.
// Define CRITICAL_WORD_FIRST_EN to fetch the missed word first and add crit_valid.
module cache_refill_ctrl #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_index_addr,
  output logic [OFF_W-1:0]  fill_word_idx,
  output logic [DATA_W-1:0] fill_data,
`ifdef CRITICAL_WORD_FIRST_EN
  output logic              crit_valid,
`endif
  output logic              refill_done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_BLOCK - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  idx;
  logic [OFF_W-1:0]  cnt;
  logic [OFF_W-1:0]  start;
  logic              take_miss;
  logic              take_rsp;
  logic              first_fill;
  logic              unused_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start = miss_addr[OFF_W+1:2];
`else
  assign start = '0;
`endif

  assign unused_addr = ^miss_addr[OFF_W+1:0];

  assign take_miss = (state == IDLE) && miss_valid;
  assign take_rsp  = (state == WAIT) && mem_rsp_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (miss_valid) state_nx = REQ;
      REQ:  if (mem_req_ready) state_nx = WAIT;
      WAIT: begin
        if (mem_rsp_valid)
          state_nx = (cnt == LAST) ? DONE : REQ;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (take_miss) begin
      base <= {miss_addr[ADDR_W-1:OFF_W+2],
               {(OFF_W+2){1'b0}}};
      idx  <= start;
      cnt  <= '0;
    end else if (take_rsp) begin
      idx  <= idx + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_we       <= 1'b0;
      fill_word_idx <= '0;
      fill_data     <= '0;
      first_fill    <= 1'b0;
    end else begin
      fill_we    <= take_rsp;
      first_fill <= take_rsp && (cnt == '0);
      if (take_rsp) begin
        fill_word_idx <= idx;
        fill_data     <= mem_rsp_data;
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  assign crit_valid = first_fill;
`else
  logic unused_first;
  assign unused_first = first_fill;
`endif

  // Offset bits come straight from idx, so the address cannot leave the block.
  assign mem_req_valid   = (state == REQ);
  assign mem_req_addr    = mem_req_valid
                         ? {base[ADDR_W-1:OFF_W+2], idx, 2'b00}
                         : '0;
  assign miss_ready      = (state == IDLE);
  assign refill_done     = (state == DONE);
  assign fill_index_addr = base;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl against a queue-based line model.
// Build with CRITICAL_WORD_FIRST_EN to exercise the wrapped fetch order.
module tb_cache_refill_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_valid = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          miss_ready;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          fill_we;
  logic [AW-1:0] fill_index_addr;
  logic [OW-1:0] fill_word_idx;
  logic [DW-1:0] fill_data;
  logic          refill_done;
`ifdef CRITICAL_WORD_FIRST_EN
  logic          crit_valid;
`endif

  cache_refill_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WORDS_PER_BLOCK(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .miss_valid(miss_valid),
    .miss_addr(miss_addr),
    .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .fill_we(fill_we),
    .fill_index_addr(fill_index_addr),
    .fill_word_idx(fill_word_idx),
    .fill_data(fill_data),
`ifdef CRITICAL_WORD_FIRST_EN
    .crit_valid(crit_valid),
`endif
    .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line model: pending request addresses/indices per accepted miss.
  bit          busy, waiting, fill_pend, done_pend, crit_pend;
  logic [31:0] req_q[$];
  int          idx_q[$];
  int          cur_idx, fill_idx_m, rcvd;
  logic [31:0] fill_data_m, fia_m;
  int          model_done, dut_done;

  // Stimulus knobs.
  int          ready_pct, rsp_pct, miss_pct, stray_pct;
  int          stall_n, stall_cnt;
  bit          seq_data, force_en;
  logic [31:0] seq_base, force_addr;

  task automatic model_clear();
    busy = 0; waiting = 0; fill_pend = 0;
    done_pend = 0; crit_pend = 0;
    req_q.delete(); idx_q.delete();
    stall_cnt = 0; rcvd = 0; fia_m = '0;
  endtask

  task automatic step();
    bit          exp_rv, acc_miss, acc_req, acc_rsp;
    logic [31:0] b;
    int          st, i;
    @(negedge clk);
    exp_rv = busy && !waiting && req_q.size() > 0;
    check("miss_ready", miss_ready, !busy);
    check("req_valid", mem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", mem_req_addr, req_q[0]);
    check("fill_we", fill_we, fill_pend);
    if (fill_pend) begin
      check("fill_idx", fill_word_idx, fill_idx_m);
      check("fill_data", fill_data, fill_data_m);
      check("fill_line", fill_index_addr, fia_m);
    end
    check("refill_done", refill_done, done_pend);
`ifdef CRITICAL_WORD_FIRST_EN
    check("crit_valid", crit_valid, crit_pend);
`endif
    if (refill_done === 1'b1) dut_done++;
    if (done_pend) model_done++;

    if (force_en) begin
      miss_valid = 1'b1;
      miss_addr  = force_addr;
    end else begin
      miss_valid = $urandom_range(99) < miss_pct;
      miss_addr  = $urandom;
    end
    if (exp_rv)
      mem_req_ready = (stall_cnt >= stall_n) &&
                      ($urandom_range(99) < ready_pct);
    else
      mem_req_ready = $urandom_range(1) == 1;
    if (waiting) begin
      mem_rsp_valid = $urandom_range(99) < rsp_pct;
      mem_rsp_data  = seq_data ? seq_base + rcvd : $urandom;
    end else begin
      mem_rsp_valid = $urandom_range(99) < stray_pct;
      mem_rsp_data  = $urandom;
    end

    acc_miss = !busy && miss_valid;
    acc_req  = exp_rv && mem_req_ready;
    acc_rsp  = waiting && mem_rsp_valid;
    if (done_pend) busy = 0;
    fill_pend = 0; done_pend = 0; crit_pend = 0;
    if (acc_miss) begin
      busy = 1;
      force_en = 0;
      b = miss_addr & ~32'(W * 4 - 1);
`ifdef CRITICAL_WORD_FIRST_EN
      st = int'((miss_addr >> 2) % W);
`else
      st = 0;
`endif
      req_q.delete(); idx_q.delete();
      for (int k = 0; k < W; k++) begin
        i = (st + k) % W;
        idx_q.push_back(i);
        req_q.push_back(b + 32'(4 * i));
      end
      rcvd = 0;
      fia_m = b;
    end
    if (acc_req) begin
      void'(req_q.pop_front());
      cur_idx = idx_q.pop_front();
      waiting = 1;
      stall_cnt = 0;
    end else if (exp_rv) begin
      stall_cnt++;
    end
    if (acc_rsp) begin
      waiting = 0;
      fill_pend = 1;
      fill_idx_m = cur_idx;
      fill_data_m = mem_rsp_data;
      crit_pend = (rcvd == 0);
      rcvd++;
      if (rcvd == W) done_pend = 1;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    miss_pct = 0;
    while ((busy || force_en) && n < 300) begin
      step();
      n++;
    end
    check("drain_timeout", busy, 0);
  endtask

  task automatic set_zero_wait();
    ready_pct = 100; rsp_pct = 100; stall_n = 0;
    miss_pct = 0; stray_pct = 0;
  endtask

  // Abort in the middle of a cycle; the outputs must clear at once.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    miss_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check("rst_fill_we", fill_we, 0);
    check("rst_done", refill_done, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_miss_ready", miss_ready, 1);
    check("rst_line", fill_index_addr, 0);
    model_clear();
    force_en = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();
    model_done = 0; dut_done = 0;
    set_zero_wait();
    seq_data = 0; seq_base = '0;
    force_en = 0; force_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check("inrst_miss_ready", miss_ready, 1);
    check("inrst_fill_we", fill_we, 0);
    #1 rst_n = 1'b1;
    step();
    check("init_line", fill_index_addr, 0);
    check("init_data", fill_data, 0);
    check("init_idx", fill_word_idx, 0);
    check("init_req_addr", mem_req_addr, 0);
    run(2);

    // Zero-wait line fill with sequential data A0..A3.
    seq_data = 1; seq_base = 32'hA0;
    force_addr = 32'h0000_0014; force_en = 1;
    run(14);
    seq_data = 0;

    // Three-cycle grant stall on every request.
    stall_n = 3;
    force_addr = 32'h0020_0016; force_en = 1;
    run(40);
    check("stall_idle", busy, 0);

    // Random traffic with stray responses and repeated misses.
    ready_pct = 60; rsp_pct = 50;
    stray_pct = 25; miss_pct = 30;
    for (int r = 0; r < 8; r++) begin
      stall_n = $urandom_range(2);
      run(80);
    end
    drain();

    // Abort after the second fill, then a clean refill.
    set_zero_wait();
    force_addr = 32'h0000_0040; force_en = 1;
    n = 0;
    while (!(busy && !force_en && rcvd == 2 && !fill_pend)
           && n < 200) begin
      step();
      n++;
    end
    check("abort_reached", n < 200, 1);
    mid_reset();
    run(4);
    force_addr = 32'h0000_0018; force_en = 1;
    stray_pct = 30;
    run(20);
    drain();

    check("done_count", dut_done, model_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
